// File: rtl/fheep_boot_ctrl.sv
// Boot/run controller for the fheep SoC: PLL-lock gated reset release, debounced
// push-button reset, strap latching, program exit capture and status LED.
module fheep_boot_ctrl #(
   parameter int unsigned LOCK_WAIT_CYCLES = 1024,
   parameter int unsigned DEBOUNCE_CYCLES  = 16,
   parameter int unsigned BLINK_LOG2       = 24
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        pll_locked_i,
   input  logic        btn_rst_i,
   input  logic        boot_select_i,
   input  logic        execute_from_flash_i,
   input  logic        exit_valid_i,
   input  logic [31:0] exit_value_i,
   output logic        sys_rst_no,
   output logic        boot_select_o,
   output logic        execute_from_flash_o,
   output logic        run_o,
   output logic        done_o,
   output logic [31:0] exit_code_o,
   output logic        status_led_o
);

   localparam int unsigned STAB_W = $clog2(LOCK_WAIT_CYCLES + 1);
   localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_WAIT_CYCLES - 1);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES);

   localparam logic [2:0] ST_RESET     = 3'd0;
   localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
   localparam logic [2:0] ST_STABLE    = 3'd2;
   localparam logic [2:0] ST_RUN       = 3'd3;
   localparam logic [2:0] ST_DONE      = 3'd4;

   logic [2:0]            state_q, state_d;
   logic                  lock_s1_q, lock_s2_q;
   logic                  btn_s1_q, btn_s2_q;
   logic [STAB_W-1:0]     stab_q, stab_d;
   logic [DB_W-1:0]       db_q, db_d;
   logic [BLINK_LOG2-1:0] cnt_q;
   logic                  btn_fire;

   logic        sys_rst_n_q, sys_rst_n_d;
   logic        boot_sel_q, boot_sel_d;
   logic        exec_flash_q, exec_flash_d;
   logic        run_q, run_d;
   logic        done_q, done_d;
   logic [31:0] exit_code_q, exit_code_d;
   logic        led_q, led_d;

   // Two-flop synchronizers for the asynchronous board inputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_s1_q <= 1'b0;
         lock_s2_q <= 1'b0;
         btn_s1_q  <= 1'b0;
         btn_s2_q  <= 1'b0;
      end else begin
         lock_s1_q <= pll_locked_i;
         lock_s2_q <= lock_s1_q;
         btn_s1_q  <= btn_rst_i;
         btn_s2_q  <= btn_s1_q;
      end
   end

   // Free-running blink counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + BLINK_LOG2'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_RESET;
         stab_q       <= '0;
         db_q         <= '0;
         sys_rst_n_q  <= 1'b0;
         boot_sel_q   <= 1'b0;
         exec_flash_q <= 1'b0;
         run_q        <= 1'b0;
         done_q       <= 1'b0;
         exit_code_q  <= '0;
         led_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         stab_q       <= stab_d;
         db_q         <= db_d;
         sys_rst_n_q  <= sys_rst_n_d;
         boot_sel_q   <= boot_sel_d;
         exec_flash_q <= exec_flash_d;
         run_q        <= run_d;
         done_q       <= done_d;
         exit_code_q  <= exit_code_d;
         led_q        <= led_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      stab_d       = stab_q;
      db_d         = '0;
      btn_fire     = 1'b0;
      boot_sel_d   = boot_sel_q;
      exec_flash_d = exec_flash_q;
      exit_code_d  = exit_code_q;
      sys_rst_n_d  = 1'b0;
      run_d        = 1'b0;
      done_d       = 1'b0;
      led_d        = 1'b0;

      // Debounce saturates, so a held button fires once until it is seen low
      if (btn_s2_q) begin
         db_d     = (db_q == DB_MAX) ? db_q : db_q + DB_W'(1);
         btn_fire = (db_q == DB_LAST);
      end

      if (btn_fire) begin
         state_d = ST_RESET;
      end else begin
         case (state_q)
            ST_RESET: begin
               state_d = ST_WAIT_LOCK;
               stab_d  = '0;
            end
            ST_WAIT_LOCK: begin
               if (lock_s2_q) begin
                  state_d = ST_STABLE;
                  stab_d  = '0;
               end
            end
            ST_STABLE: begin
               if (!lock_s2_q) begin
                  state_d = ST_WAIT_LOCK;
                  stab_d  = '0;
               end else if (stab_q == STAB_LAST) begin
                  state_d      = ST_RUN;
                  boot_sel_d   = boot_select_i;
                  exec_flash_d = execute_from_flash_i;
               end else begin
                  stab_d = stab_q + STAB_W'(1);
               end
            end
            ST_RUN: begin
               if (!lock_s2_q) begin
                  state_d = ST_RESET;
               end else if (exit_valid_i) begin
                  state_d     = ST_DONE;
                  exit_code_d = exit_value_i;
               end
            end
            ST_DONE: begin
               if (!lock_s2_q) begin
                  state_d = ST_RESET;
               end
            end
            default: state_d = ST_RESET;
         endcase
      end

      if (state_d == ST_RESET) begin
         exit_code_d = '0;
      end

      // Outputs are registered from the next state so they switch with it
      sys_rst_n_d = (state_d == ST_RUN) || (state_d == ST_DONE);
      run_d       = (state_d == ST_RUN);
      done_d      = (state_d == ST_DONE);
      case (state_d)
         ST_RUN:  led_d = cnt_q[BLINK_LOG2-1];
         ST_DONE: led_d = (exit_code_d == 32'd0) ? 1'b1 : cnt_q[BLINK_LOG2-3];
         default: led_d = 1'b0;
      endcase
   end

   assign sys_rst_no           = sys_rst_n_q;
   assign boot_select_o        = boot_sel_q;
   assign execute_from_flash_o = exec_flash_q;
   assign run_o                = run_q;
   assign done_o               = done_q;
   assign exit_code_o          = exit_code_q;
   assign status_led_o         = led_q;

endmodule

// File: tb/tb_fheep_boot_ctrl.sv
// Directed self-checking bench for fheep_boot_ctrl with small timing parameters.
module tb_fheep_boot_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        pll_locked_i;
   logic        btn_rst_i;
   logic        boot_select_i;
   logic        execute_from_flash_i;
   logic        exit_valid_i;
   logic [31:0] exit_value_i;
   logic        sys_rst_no;
   logic        boot_select_o;
   logic        execute_from_flash_o;
   logic        run_o;
   logic        done_o;
   logic [31:0] exit_code_o;
   logic        status_led_o;

   int n_tests = 0;
   int n_fail  = 0;

   fheep_boot_ctrl #(
      .LOCK_WAIT_CYCLES(8),
      .DEBOUNCE_CYCLES (4),
      .BLINK_LOG2      (6)
   ) dut (
      .clk_i               (clk_i),
      .rst_ni              (rst_ni),
      .pll_locked_i        (pll_locked_i),
      .btn_rst_i           (btn_rst_i),
      .boot_select_i       (boot_select_i),
      .execute_from_flash_i(execute_from_flash_i),
      .exit_valid_i        (exit_valid_i),
      .exit_value_i        (exit_value_i),
      .sys_rst_no          (sys_rst_no),
      .boot_select_o       (boot_select_o),
      .execute_from_flash_o(execute_from_flash_o),
      .run_o               (run_o),
      .done_o              (done_o),
      .exit_code_o         (exit_code_o),
      .status_led_o        (status_led_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      logic [31:0] packed_o;
      packed_o = {25'd0, sys_rst_no, boot_select_o, execute_from_flash_o,
                  run_o, done_o, status_led_o, 1'b0};
      check_eq({tag, "_ctl"}, packed_o, 32'd0);
      check_eq({tag, "_exit"}, exit_code_o, 32'd0);
   endtask

   // Reset, release, raise lock: release must land on edge 11 after first lock sample
   task automatic do_boot(input string tag, input logic bsel, input logic xflash);
      rst_ni       = 1'b0;
      pll_locked_i = 1'b0;
      btn_rst_i    = 1'b0;
      exit_valid_i = 1'b0;
      tick();
      check_all_zero({tag, "_rst"});
      rst_ni = 1'b1;
      tick();
      tick();
      boot_select_i        = bsel;
      execute_from_flash_i = xflash;
      pll_locked_i         = 1'b1;
      for (int e = 1; e <= 10; e++) tick();
      check_eq({tag, "_pre_release"}, 32'(sys_rst_no), 32'd0);
      tick();
      check_eq({tag, "_release"}, 32'(sys_rst_no), 32'd1);
      check_eq({tag, "_run"}, 32'(run_o), 32'd1);
      check_eq({tag, "_bsel"}, 32'(boot_select_o), 32'(bsel));
      check_eq({tag, "_xflash"}, 32'(execute_from_flash_o), 32'(xflash));
   endtask

   initial begin
      int prev_led;
      int run_len;
      int changes;

      rst_ni               = 1'b0;
      pll_locked_i         = 1'b0;
      btn_rst_i            = 1'b0;
      boot_select_i        = 1'b0;
      execute_from_flash_i = 1'b0;
      exit_valid_i         = 1'b0;
      exit_value_i         = 32'd0;
      #2;
      check_all_zero("reset_state");

      // Normal boot, then straps must stay frozen while the inputs move
      do_boot("boot1", 1'b1, 1'b0);
      boot_select_i        = 1'b0;
      execute_from_flash_i = 1'b1;
      tick();
      check_eq("strap_hold_bsel", 32'(boot_select_o), 32'd1);
      check_eq("strap_hold_xflash", 32'(execute_from_flash_o), 32'd0);

      do_boot("boot2", 1'b0, 1'b1);

      // Lock glitch at stability count 5 (after edge 8)
      rst_ni       = 1'b0;
      pll_locked_i = 1'b0;
      tick();
      rst_ni = 1'b1;
      tick();
      tick();
      pll_locked_i = 1'b1;
      for (int e = 1; e <= 8; e++) tick();
      pll_locked_i = 1'b0;
      for (int e = 9; e <= 11; e++) begin
         tick();
         check_eq($sformatf("glitch_low_e%0d", e), 32'(sys_rst_no), 32'd0);
      end
      pll_locked_i = 1'b1;
      for (int e = 12; e <= 21; e++) begin
         tick();
         check_eq($sformatf("glitch_wait_e%0d", e), 32'(sys_rst_no), 32'd0);
      end
      tick();
      check_eq("glitch_release_e22", 32'(sys_rst_no), 32'd1);

      // Exit pass
      exit_valid_i = 1'b1;
      exit_value_i = 32'd0;
      tick();
      exit_valid_i = 1'b0;
      check_eq("pass_done", 32'(done_o), 32'd1);
      check_eq("pass_run", 32'(run_o), 32'd0);
      check_eq("pass_code", exit_code_o, 32'd0);
      for (int i = 0; i < 12; i++) begin
         check_eq($sformatf("pass_led_%0d", i), 32'(status_led_o), 32'd1);
         tick();
      end

      // Exit fail, fast blink, later exit ignored
      do_boot("boot3", 1'b1, 1'b1);
      exit_valid_i = 1'b1;
      exit_value_i = 32'h0000_002A;
      tick();
      exit_valid_i = 1'b0;
      check_eq("fail_done", 32'(done_o), 32'd1);
      check_eq("fail_code", exit_code_o, 32'h0000_002A);
      prev_led = int'(status_led_o);
      run_len  = 0;
      changes  = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         run_len++;
         if (int'(status_led_o) != prev_led) begin
            if (changes > 0) check_eq($sformatf("fail_blink_%0d", changes), 32'(run_len), 32'd8);
            changes++;
            run_len  = 0;
            prev_led = int'(status_led_o);
         end
      end
      check_eq("fail_blink_toggles", 32'(changes >= 4), 32'd1);
      exit_valid_i = 1'b1;
      exit_value_i = 32'h0000_0055;
      tick();
      exit_valid_i = 1'b0;
      tick();
      check_eq("second_exit_ignored", exit_code_o, 32'h0000_002A);
      check_eq("second_exit_done", 32'(done_o), 32'd1);

      // Button: short pulse ignored, long press resets, held press does not re-fire
      do_boot("boot4", 1'b1, 1'b0);
      btn_rst_i = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      btn_rst_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check_eq($sformatf("short_btn_%0d", i), 32'(sys_rst_no), 32'd1);
      end
      exit_valid_i = 1'b1;
      exit_value_i = 32'h0000_0013;
      tick();
      exit_valid_i = 1'b0;
      check_eq("btn_pre_code", exit_code_o, 32'h0000_0013);
      btn_rst_i = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         tick();
         check_eq($sformatf("btn_debounce_e%0d", e), 32'(sys_rst_no), 32'd1);
      end
      tick();
      check_eq("btn_reset", 32'(sys_rst_no), 32'd0);
      check_eq("btn_code_clr", exit_code_o, 32'd0);
      check_eq("btn_done_clr", 32'(done_o), 32'd0);
      for (int e = 7; e <= 15; e++) tick();
      check_eq("btn_reboot_e15", 32'(sys_rst_no), 32'd0);
      tick();
      check_eq("btn_reboot_e16", 32'(sys_rst_no), 32'd1);
      for (int i = 0; i < 10; i++) begin
         tick();
         check_eq($sformatf("btn_held_%0d", i), 32'(sys_rst_no), 32'd1);
      end
      btn_rst_i = 1'b0;
      tick();
      tick();

      // Priority: button completes on the same edge as exit_valid
      btn_rst_i = 1'b1;
      for (int e = 1; e <= 5; e++) tick();
      exit_valid_i = 1'b1;
      exit_value_i = 32'h0000_0077;
      tick();
      exit_valid_i = 1'b0;
      btn_rst_i    = 1'b0;
      check_eq("prio_btn_rst", 32'(sys_rst_no), 32'd0);
      check_eq("prio_btn_done", 32'(done_o), 32'd0);
      check_eq("prio_btn_code", exit_code_o, 32'd0);

      // Lock loss in RUN beats exit_valid on the same edge
      do_boot("boot5", 1'b0, 1'b0);
      pll_locked_i = 1'b0;
      tick();
      tick();
      check_eq("lockloss_sync", 32'(sys_rst_no), 32'd1);
      exit_valid_i = 1'b1;
      exit_value_i = 32'h0000_0099;
      tick();
      exit_valid_i = 1'b0;
      check_eq("lockloss_rst", 32'(sys_rst_no), 32'd0);
      check_eq("lockloss_done", 32'(done_o), 32'd0);
      check_eq("lockloss_code", exit_code_o, 32'd0);

      // Async reset between edges while running
      do_boot("boot6", 1'b1, 1'b1);
      #2;
      rst_ni = 1'b0;
      #1;
      check_all_zero("async_rst");
      tick();
      rst_ni = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
